// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Multi-port decode-stage register file. It provides:
//   * NRD combinational read ports with same-cycle write-to-read bypass.
//     Port B has priority over port A.
//   * Two write ports: A for ALU writeback and B for load writeback. If both
//     write the same address in one cycle, port B wins.
//   * A per-register pending-load scoreboard. It flags reads whose source
//     still waits on a load.
//   * A clear engine. It zeroes one register per cycle and holds busy high
//     for the whole sweep.
// Index NREG-1 is the PC. It has no storage. Reads of it return pc_in, and
// writes or reservations to it are dropped.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear_req  start a clear sweep (accepted in IDLE only)
//   busy       clear sweep in progress
//   we_a/wa_a/wd_a  write port A (ALU writeback)
//   we_b/wa_b/wd_b  write port B (load writeback, also retires pend bits)
//   ra         packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd         packed read data, port i at [i*DATA_W +: DATA_W]
//   pc_in      PC+8 value returned for reads of index NREG-1
//   rsv_en/rsv_addr  mark a register as destination of an outstanding load
//   pend       per read port: source register has an outstanding load
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic [DATA_W-1:0]       wd_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic [DATA_W-1:0]       wd_b,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic [NRD-1:0]          pend
);

  localparam int NREG   = 2 ** ADDR_W;
  localparam int NSTORE = NREG - 1;
  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 2);

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                busy_q;
  logic                idle;

  assign idle = (state_q == ST_IDLE);
  assign busy = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // The last stored register ends the sweep. The counter never
          // reaches the PC index.
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage and scoreboard, one slice per architectural register.
  // rf_view/pend_view span the full address space. The PC slot is fed from
  // pc_in and a constant 0, so read ports index them directly.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_view [NREG];
  logic [NREG-1:0]   pend_view;

  assign rf_view[NREG-1]   = pc_in;
  assign pend_view[NREG-1] = 1'b0;

  for (genvar gi = 0; gi < NSTORE; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic              pend_bit_q;
    logic              pend_bit_d;
    logic              clr_hit;
    logic              wr_a_hit;
    logic              wr_b_hit;
    logic              rsv_hit;

    assign clr_hit  = (state_q == ST_CLEAR) && (cnt_q == IDX);
    assign wr_a_hit = idle && we_a && (wa_a == IDX);
    assign wr_b_hit = idle && we_b && (wa_b == IDX);
    assign rsv_hit  = idle && rsv_en && (rsv_addr == IDX);

    always_comb begin
      word_d     = word_q;
      pend_bit_d = pend_bit_q;
      if (clr_hit) begin
        word_d     = '0;
        pend_bit_d = 1'b0;
      end else begin
        if (wr_b_hit) begin
          word_d = wd_b;
        end else if (wr_a_hit) begin
          word_d = wd_a;
        end
        // A new reservation outranks a retiring load to the same register.
        if (rsv_hit) begin
          pend_bit_d = 1'b1;
        end else if (wr_b_hit) begin
          pend_bit_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_q     <= '0;
        pend_bit_q <= 1'b0;
      end else begin
        word_q     <= word_d;
        pend_bit_q <= pend_bit_d;
      end
    end

    assign rf_view[gi]   = word_q;
    assign pend_view[gi] = pend_bit_q;
  end : g_reg

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] word;

    assign addr  = ra[gi*ADDR_W +: ADDR_W];
    // Bypass is disabled while sweeping, because the writes are dropped
    // then.
    assign byp_b = idle && we_b && (wa_b == addr);
    assign byp_a = idle && we_a && (wa_a == addr);

    always_comb begin
      word = rf_view[addr];
      if (addr == PC_IDX) begin
        word = pc_in;
      end else if (byp_b) begin
        word = wd_b;
      end else if (byp_a) begin
        word = wd_a;
      end
    end

    assign rd[gi*DATA_W +: DATA_W] = word;
    // A load landing this cycle is forwarded, so it no longer stalls.
    assign pend[gi] = pend_view[addr] && !byp_b;
  end : g_rd

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NRD    = 3;
  localparam int NREG   = 2 ** ADDR_W;
  localparam int PCI    = NREG - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  clear_req;
  logic                  busy;
  logic                  we_a;
  logic [ADDR_W-1:0]     wa_a;
  logic [DATA_W-1:0]     wd_a;
  logic                  we_b;
  logic [ADDR_W-1:0]     wa_b;
  logic [DATA_W-1:0]     wd_b;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [DATA_W-1:0]     pc_in;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic [NRD-1:0]        pend;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .we_a      (we_a),
    .wa_a      (wa_a),
    .wd_a      (wd_a),
    .we_b      (we_b),
    .wa_b      (wa_b),
    .wd_b      (wd_b),
    .ra        (ra),
    .rd        (rd),
    .pc_in     (pc_in),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .pend      (pend)
  );

  initial forever #5 clk = ~clk;

  // Reference model: architectural contents plus clear-sweep progress.
  logic [DATA_W-1:0] m_mem [NREG-1];
  bit                m_pend [NREG-1];
  bit                m_busy;
  int                m_pos;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  task automatic check_word(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG - 1; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 1'b0;
    end
    m_busy = 1'b0;
    m_pos  = 0;
  endtask

  function automatic logic [ADDR_W-1:0] port_addr(input int p);
    return ra[p*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input int p);
    int a;
    a = int'(port_addr(p));
    if (a == PCI) return pc_in;
    if (!m_busy && we_b && int'(wa_b) == a) return wd_b;
    if (!m_busy && we_a && int'(wa_a) == a) return wd_a;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input int p);
    int a;
    a = int'(port_addr(p));
    if (a == PCI) return 1'b0;
    return m_pend[a] && !(!m_busy && we_b && int'(wa_b) == a);
  endfunction

  // Effect of one rising edge on the architectural state.
  task automatic model_edge();
    if (m_busy) begin
      m_mem[m_pos]  = '0;
      m_pend[m_pos] = 1'b0;
      if (m_pos == NREG - 2) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end else begin
      if (we_a && int'(wa_a) != PCI) m_mem[int'(wa_a)] = wd_a;
      if (we_b && int'(wa_b) != PCI) m_mem[int'(wa_b)] = wd_b;
      if (we_b && int'(wa_b) != PCI) m_pend[int'(wa_b)] = 1'b0;
      if (rsv_en && int'(rsv_addr) != PCI) m_pend[int'(rsv_addr)] = 1'b1;
      if (clear_req) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic half_check();
    @(negedge clk);
    for (int p = 0; p < NRD; p++) begin
      check_word($sformatf("rd%0d", p), rd[p*DATA_W +: DATA_W], exp_rd(p));
      check_bit($sformatf("pend%0d", p), pend[p], exp_pend(p));
    end
    check_bit("busy", busy, m_busy);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    $display("txn %0d: we_a=%0b wa_a=%0d wd_a=%08h we_b=%0b wa_b=%0d wd_b=%08h rsv=%0b/%0d clr=%0b busy=%0b",
             txn, we_a, wa_a, wd_a, we_b, wa_b, wd_b, rsv_en, rsv_addr, clear_req, m_busy);
    txn++;
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2);
    ra[0*ADDR_W +: ADDR_W] = ADDR_W'(a0);
    ra[1*ADDR_W +: ADDR_W] = ADDR_W'(a1);
    ra[2*ADDR_W +: ADDR_W] = ADDR_W'(a2);
  endtask

  initial begin
    int busy_cycles;
    reset = 1'b0;
    idle_inputs();
    set_ra(0, 1, 2);
    pc_in = 32'h0000_0108;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    half_check();
    check_bit("reset_busy", busy, 1'b0);
    check_word("reset_rd0", rd[0 +: DATA_W], 32'h0);
    clk_edge();

    // Basic write, then read back alongside a PC read.
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hDEADBEEF;
    half_check();
    clk_edge();
    idle_inputs();
    set_ra(3, 15, 0);
    pc_in = 32'h0000_0108;
    half_check();
    check_word("rd0_reg3", rd[0 +: DATA_W], 32'hDEADBEEF);
    check_word("rd1_pc", rd[DATA_W +: DATA_W], 32'h0000_0108);
    clk_edge();

    // Dual write to one address: port B wins, including on the bypass path.
    we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h11;
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h22;
    set_ra(5, 0, 0);
    half_check();
    check_word("bypass_b_wins", rd[0 +: DATA_W], 32'h22);
    clk_edge();
    idle_inputs();
    half_check();
    check_word("stored_b_wins", rd[0 +: DATA_W], 32'h22);
    clk_edge();

    // Reserve, observe pend, then retire it with a forwarded load.
    rsv_en = 1'b1; rsv_addr = 4'd7;
    half_check();
    clk_edge();
    idle_inputs();
    set_ra(0, 0, 7);
    half_check();
    check_bit("pend_set", pend[2], 1'b1);
    clk_edge();
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h55;
    half_check();
    check_bit("pend_bypass", pend[2], 1'b0);
    check_word("rd2_load_bypass", rd[2*DATA_W +: DATA_W], 32'h55);
    clk_edge();
    idle_inputs();
    half_check();
    check_bit("pend_retired", pend[2], 1'b0);
    clk_edge();

    // Set and clear on the same edge: set wins.
    rsv_en = 1'b1; rsv_addr = 4'd4;
    we_b = 1'b1; wa_b = 4'd4; wd_b = 32'h44;
    half_check();
    clk_edge();
    idle_inputs();
    set_ra(4, 15, 1);
    half_check();
    check_bit("pend_set_wins", pend[0], 1'b1);
    clk_edge();

    // Full clear sweep, with writes offered during the window.
    for (int r = 0; r < NREG - 1; r++) begin
      we_a = 1'b1; wa_a = ADDR_W'(r); wd_a = 32'h1000 + 32'(r) + 1;
      rsv_en = (r % 3 == 0); rsv_addr = ADDR_W'(r);
      half_check();
      clk_edge();
    end
    idle_inputs();
    clear_req = 1'b1;
    half_check();
    clk_edge();
    clear_req = 1'b0;
    we_a = 1'b1; wa_a = 4'd2; wd_a = 32'hAAAA_AAAA;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      set_ra(k % NREG, (k + 5) % NREG, (k + 9) % NREG);
      half_check();
      if (!busy) break;
      busy_cycles++;
      clk_edge();
      #1;
    end
    check_word("busy_len", 32'(busy_cycles), 32'd15);
    idle_inputs();
    for (int r = 0; r < NREG - 1; r++) begin
      set_ra(r, r, r);
      half_check();
      check_word($sformatf("cleared_r%0d", r), rd[0 +: DATA_W], 32'h0);
      check_bit($sformatf("cleared_pend%0d", r), pend[1], 1'b0);
      clk_edge();
    end

    // Asynchronous reset in the middle of a sweep (counter at 6).
    for (int r = 0; r < NREG - 1; r++) begin
      we_a = 1'b1; wa_a = ADDR_W'(r); wd_a = 32'h2000 + 32'(r) + 1;
      half_check();
      clk_edge();
    end
    idle_inputs();
    clear_req = 1'b1;
    clk_edge();
    clear_req = 1'b0;
    repeat (6) clk_edge();
    set_ra(8, 9, 10);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_bit("async_busy", busy, 1'b0);
    check_word("async_rd0", rd[0 +: DATA_W], 32'h0);
    check_word("async_rd2", rd[2*DATA_W +: DATA_W], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    we_a = 1'b1; wa_a = 4'd9; wd_a = 32'h77;
    clk_edge();
    idle_inputs();
    half_check();
    check_word("post_reset_write", rd[DATA_W +: DATA_W], 32'h77);
    clk_edge();

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      clear_req = ($urandom_range(0, 39) == 0);
      we_a      = 1'($urandom_range(0, 1));
      wa_a      = ADDR_W'($urandom_range(0, NREG - 1));
      wd_a      = $urandom;
      we_b      = 1'($urandom_range(0, 1));
      wa_b      = ADDR_W'($urandom_range(0, NREG - 1));
      wd_b      = $urandom;
      rsv_en    = 1'($urandom_range(0, 1));
      rsv_addr  = ADDR_W'($urandom_range(0, NREG - 1));
      pc_in     = $urandom;
      for (int p = 0; p < NRD; p++) begin
        // Aim reads at recently written registers half the time.
        ra[p*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ?
            (($urandom_range(0, 1) == 1) ? wa_b : wa_a) :
            ADDR_W'($urandom_range(0, NREG - 1));
      end
      half_check();
      clk_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file_mp

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor of the pipeline's 3-port register file.
- Provides NRD combinational read ports and two write ports: port A for ALU writeback, port B for load writeback.
- Adds same-cycle write-to-read bypass, a per-register pending-load scoreboard for hazard detection, and a sequenced clear engine.
- Sits in the decode stage. The top architectural index reads the externally supplied PC+8 value and has no storage.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 4, register address width; NREG = 2**ADDR_W, index NREG-1 is the PC
NRD, 3, number of read ports (at least 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
clear_req  in  1  start clear sequence (single-cycle pulse or level)
busy  out  1  clear sequence in progress
we_a  in  1  write enable, port A
wa_a  in  ADDR_W  write address, port A
wd_a  in  DATA_W  write data, port A
we_b  in  1  write enable, port B
wa_b  in  ADDR_W  write address, port B
wd_b  in  DATA_W  write data, port B
ra  in  NRD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
pc_in  in  DATA_W  PC+8 value, returned for reads of index NREG-1
rsv_en  in  1  reserve a pending load destination
rsv_addr  in  ADDR_W  register to reserve
pend  out  NRD  per read port: the source register has an outstanding load

Behaviour:
- Storage: NREG-1 registers, indices 0..NREG-2.
- Reset (reset=0, asynchronous):
  - All registers 0, all pend bits 0.
  - FSM in IDLE; busy=0; clear counter 0.
  - rd outputs follow combinationally from the cleared state.
- Write (IDLE only): rising edge; stores wd_a at wa_a if we_a, and wd_b at wa_b if we_b.
  - Both ports enabled to the same address: port B wins.
  - Writes to index NREG-1 are ignored.
- Read, port i (combinational, zero latency), priority order:
  1. ra_i == NREG-1 -> pc_in.
  2. IDLE and we_b and wa_b == ra_i -> wd_b.
  3. IDLE and we_a and wa_a == ra_i -> wd_a.
  4. Otherwise -> stored value.
- Scoreboard: one pend_bit per stored register, updated at the rising edge in IDLE.
  - rsv_en sets pend_bit[rsv_addr].
  - we_b clears pend_bit[wa_b].
  - Set and clear to the same address in the same cycle: set wins (a new load is outstanding).
  - rsv_addr == NREG-1 is ignored.
  - we_a does not affect pend bits.
- pend output, port i: pend_bit[ra_i] and not (IDLE and we_b and wa_b == ra_i).
  - The bypass resolves the hazard in the same cycle.
  - Always 0 for index NREG-1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear_req=1 -> CLEAR at the next edge; counter=0; busy=1 from that edge.
  - CLEAR: each edge writes 0 to reg[counter], clears pend_bit[counter], then increments counter.
  - When counter == NREG-2 is written, return to IDLE; busy=0 after that edge.
  - busy is high for exactly NREG-1 cycles.
  - In CLEAR: we_a, we_b, rsv_en and clear_req are ignored, bypass is disabled, and reads return stored values (partially cleared).
  - Counter width is ADDR_W; no wrap beyond NREG-2.
- Reset asserted mid-CLEAR: immediate return to IDLE with all state zeroed.

Test Plan:
- Reset, then we_a=1, wa_a=3, wd_a=0xDEADBEEF; next cycle read ra0=3 -> rd0=0xDEADBEEF; ra1=15 with pc_in=0x108 -> rd1=0x108.
- Same cycle: we_a wa_a=5 wd_a=0x11, we_b wa_b=5 wd_b=0x22, ra0=5 -> rd0=0x22 combinationally; stored value 0x22 afterwards.
- rsv_en rsv_addr=7; next cycle ra2=7 -> pend[2]=1. Then we_b wa_b=7 wd_b=0x55 -> same cycle pend[2]=0 and rd2=0x55; pend stays 0 afterwards.
- Same edge: rsv_en rsv_addr=4 and we_b wa_b=4 -> pend for reg 4 is 1 after the edge.
- Fill regs 0..14 with nonzero values, pulse clear_req -> busy high exactly 15 cycles, we_a ignored during that window, then all regs read 0 and all pend 0.
- Pulse reset low mid-CLEAR (counter=6) -> busy=0 and all regs 0 immediately, with no clock edge required; writes accepted on the next edge.
